// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one memory read per instruction, presents the
// returned word with a one-cycle valid pulse, and stops on the halt encoding.
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   output logic [15:0] pc,
   output logic        halted
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic [15:0] r_instr, w_instr_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 16'h0000;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      if (r_state == S_HALT) begin
         if (redirect) begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = S_FETCH;
         end
      end else if (redirect) begin
         // Redirect wins over increment and any same-cycle read data, which is dropped.
         w_pc_nxt    = redirect_pc;
         w_state_nxt = stall ? S_IDLE : S_FETCH;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!stall) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  w_instr_nxt = imem_rdata;
                  w_state_nxt = (imem_rdata == HALT_WORD) ? S_HALT : S_ISSUE;
               end
            end
            S_ISSUE: begin
               w_pc_nxt    = r_pc + 16'd1;
               w_state_nxt = stall ? S_IDLE : S_FETCH;
            end
            default: ;
         endcase
      end
   end

   assign imem_req    = (r_state == S_FETCH);
   assign imem_addr   = r_pc;
   assign pc          = r_pc;
   assign instr       = r_instr;
   assign instr_valid = (r_state == S_ISSUE);
   assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by random traffic, each cycle compared against a
// transaction-level model of the fetch rules.
module tb_fetch_unit;

   localparam logic [15:0] RESET_PC  = 16'h0000;
   localparam logic [15:0] HALT_WORD = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst, stall, redirect, imem_ready;
   logic [15:0] redirect_pc, imem_rdata;
   logic        imem_req, instr_valid, halted;
   logic [15:0] imem_addr, instr, pc;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: pc, held instruction, and three facts -- a read is outstanding,
   // a fresh instruction is being presented, fetch has stopped.
   logic [15:0] m_pc, m_instr;
   bit          m_req, m_pulse, m_halt;

   fetch_unit #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .pc(pc), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, s, rd, input logic [15:0] rpc,
                             input bit rdy, input logic [15:0] rdat);
      if (r) begin
         m_pc = RESET_PC; m_instr = 16'h0000;
         m_req = 0; m_pulse = 0; m_halt = 0;
      end else if (m_halt) begin
         if (rd) begin m_pc = rpc; m_halt = 0; m_req = 1; end
      end else if (rd) begin
         m_pc = rpc; m_req = !s; m_pulse = 0;
      end else if (m_pulse) begin
         m_pc = m_pc + 16'd1; m_pulse = 0; m_req = !s;
      end else if (m_req) begin
         if (rdy) begin
            m_instr = rdat; m_req = 0;
            if (rdat == HALT_WORD) m_halt = 1; else m_pulse = 1;
         end
      end else begin
         m_req = !s;
      end
   endtask

   task automatic check_all();
      chk("pc",          pc,          m_pc);
      chk("imem_addr",   imem_addr,   m_pc);
      chk("instr",       instr,       m_instr);
      chk("imem_req",    {15'd0, imem_req},    {15'd0, m_req});
      chk("instr_valid", {15'd0, instr_valid}, {15'd0, m_pulse});
      chk("halted",      {15'd0, halted},      {15'd0, m_halt});
   endtask

   // One clock: drive inputs, advance model at the edge, compare at the falling edge.
   task automatic step(input bit r, s, rd, input logic [15:0] rpc,
                       input bit rdy, input logic [15:0] rdat);
      rst = r; stall = s; redirect = rd; redirect_pc = rpc;
      imem_ready = rdy; imem_rdata = rdat;
      @(posedge clk);
      model_edge(r, s, rd, rpc, rdy, rdat);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_req = 0; m_pulse = 0; m_halt = 0;
      @(negedge clk);
      step(1, 0, 0, 16'h0, 0, 16'h0);
      step(1, 0, 0, 16'h0, 0, 16'h0);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_req", {15'd0, imem_req}, 16'd0);

      // Sequential run of three words
      step(0, 0, 0, 16'h0, 0, 16'h0);
      step(0, 0, 0, 16'h0, 1, 16'h1111);
      chk("seq0_valid", {15'd0, instr_valid}, 16'd1);
      chk("seq0_instr", instr, 16'h1111);
      step(0, 0, 0, 16'h0, 0, 16'h0);
      step(0, 0, 0, 16'h0, 1, 16'h2222);
      chk("seq1_pc", pc, 16'h0001);
      step(0, 0, 0, 16'h0, 0, 16'h0);
      step(0, 0, 0, 16'h0, 1, 16'h3333);
      chk("seq2_pc", pc, 16'h0002);
      chk("seq2_instr", instr, 16'h3333);
      step(0, 0, 0, 16'h0, 0, 16'h0);

      // Stall during issue at pc=3
      step(0, 0, 0, 16'h0, 1, 16'h4444);
      chk("stall_pulse", {15'd0, instr_valid}, 16'd1);
      step(0, 1, 0, 16'h0, 0, 16'h0);
      chk("stall_pc", pc, 16'h0004);
      chk("stall_req", {15'd0, imem_req}, 16'd0);
      step(0, 1, 0, 16'h0, 0, 16'h0);
      step(0, 0, 0, 16'h0, 0, 16'h0);
      chk("resume_addr", imem_addr, 16'h0004);

      // Wait states at pc=5
      step(0, 0, 0, 16'h0, 1, 16'h5555);
      step(0, 0, 0, 16'h0, 0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 16'h0, 0, 16'h0);
         chk("wait_addr", imem_addr, 16'h0005);
      end
      step(0, 0, 0, 16'h0, 1, 16'h6666);
      chk("wait_pulse", {15'd0, instr_valid}, 16'd1);
      step(0, 0, 0, 16'h0, 0, 16'h0);

      // Redirect colliding with ready
      step(0, 0, 1, 16'h0040, 1, 16'hABCD);
      chk("coll_instr", instr, 16'h6666);
      chk("coll_addr", imem_addr, 16'h0040);
      step(0, 0, 0, 16'h0, 0, 16'h0);
      chk("coll_nopulse", {15'd0, instr_valid}, 16'd0);

      // Halt at pc=7, then redirect out
      step(0, 0, 1, 16'h0007, 0, 16'h0);
      step(0, 0, 0, 16'h0, 1, 16'hFFFF);
      for (int i = 0; i < 4; i++) step(0, i[0], 0, 16'h0, 1, 16'h1234);
      chk("halt_flag", {15'd0, halted}, 16'd1);
      chk("halt_pc", pc, 16'h0007);
      chk("halt_instr", instr, 16'hFFFF);
      step(0, 0, 1, 16'h0010, 0, 16'h0);
      chk("unhalt_addr", imem_addr, 16'h0010);
      chk("unhalt_flag", {15'd0, halted}, 16'd0);

      // Reset while a response arrives
      step(1, 0, 0, 16'h0, 1, 16'h1234);
      chk("rstmid_instr", instr, 16'h0000);
      chk("rstmid_pc", pc, RESET_PC);

      // Wrap-around
      step(0, 0, 0, 16'h0, 0, 16'h0);
      step(0, 0, 1, 16'hFFFF, 0, 16'h0);
      step(0, 0, 0, 16'h0, 1, 16'h0123);
      step(0, 0, 0, 16'h0, 0, 16'h0);
      chk("wrap_addr", imem_addr, 16'h0000);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] d;
         d = ($urandom_range(0, 15) == 0) ? HALT_WORD : 16'($urandom);
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0, 16'($urandom),
              $urandom_range(0, 1) == 1, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 16'h0000, giving the PC value loaded on reset.
REQ-002 The module SHALL have parameter HALT_WORD, default 16'hFFFF, giving the instruction encoding that halts fetch.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, and SHALL list these ports first:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
REQ-004 The module SHALL have these remaining ports:
- stall  in  1  hold the current instr/pc; no new fetch.
- redirect  in  1  branch or jump taken; load the PC from redirect_pc.
- redirect_pc  in  16  redirect target word address.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  16  instruction memory word address (equals pc).
- imem_ready  in  1  imem_rdata is valid this cycle.
- imem_rdata  in  16  instruction word from memory.
- instr  out  16  fetched instruction; drives the downstream instruction register input.
- instr_valid  out  1  one-cycle pulse: instr is new.
- pc  out  16  address of the current fetch.
- halted  out  1  HALT_WORD was fetched; fetch has stopped.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, FETCH, ISSUE, HALT.
REQ-006 In IDLE, if stall=0, the FSM SHALL go to FETCH on the next edge; otherwise it SHALL stay in IDLE.
REQ-007 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-008 In FETCH with imem_ready=1 and redirect=0:
- instr SHALL register imem_rdata.
- The FSM SHALL go to ISSUE, or to HALT if imem_rdata==HALT_WORD.
REQ-009 In FETCH with imem_ready=0, the FSM SHALL stay in FETCH with imem_req held at 1 and imem_addr stable.
REQ-010 In ISSUE, instr_valid SHALL be 1 for exactly that one cycle.
REQ-011 On leaving ISSUE with redirect=0, pc SHALL become pc+1 (16-bit, FFFF wraps to 0000).
REQ-012 On leaving ISSUE, the FSM SHALL go to FETCH if stall=0, else to IDLE.
REQ-013 The best-case rate SHALL be one instruction per 2 cycles, with a latency of 1 cycle from imem_ready to instr_valid.
REQ-014 A redirect=1 seen in IDLE, FETCH or ISSUE SHALL load pc with redirect_pc and send the FSM to FETCH (IDLE if stall=1).
REQ-015 A redirect SHALL take priority over the pc+1 increment, stall, and a same-cycle imem_ready.
REQ-016 The data returned with a same-cycle redirect SHALL be discarded: instr is unchanged and no instr_valid pulse follows.
REQ-017 In ISSUE, stall SHALL NOT suppress the instr_valid pulse; it only blocks the next fetch.
REQ-018 stall=1 in FETCH SHALL NOT abort an outstanding request; the request completes per REQ-008.
REQ-019 instr SHALL hold its last value whenever no new instruction is captured.
REQ-020 In HALT:
- halted SHALL be 1, imem_req 0 and instr_valid 0.
- pc SHALL keep the HALT_WORD address.
- Only rst or redirect SHALL leave HALT; a redirect goes to FETCH.
REQ-021 The HALT_WORD itself SHALL be captured in instr but SHALL NOT produce an instr_valid pulse.

Reset
REQ-022 When rst=1 at a clock edge, the block SHALL set: state=IDLE, pc=RESET_PC, instr=16'h0000, instr_valid=0, imem_req=0, halted=0.
REQ-023 rst SHALL override all other inputs, including during FETCH with imem_ready=1.
REQ-024 Any in-flight memory response arriving in the reset cycle SHALL be dropped.

Verification
REQ-025 Sequential run: reset, then memory returns 16'h1111, 16'h2222, 16'h3333 with ready=1 each FETCH cycle -> instr_valid pulses every 2nd cycle, pc steps 0,1,2, instr follows the returned words.
REQ-026 Wait states: imem_ready=0 for 3 cycles at pc=5 -> imem_req=1 and imem_addr=5 held for 4 cycles, then one instr_valid pulse.
REQ-027 Redirect collision: redirect=1, redirect_pc=16'h0040 in the same FETCH cycle as imem_ready=1 with rdata=16'hABCD:
- instr does not become ABCD and no instr_valid pulse follows.
- The next imem_addr is 0040.
REQ-028 Halt: memory returns 16'hFFFF at pc=7 -> halted=1 and imem_req=0 forever; pc stays 7.
- A later redirect to 16'h0010 clears halted and fetches from 0010.
REQ-029 Stall: stall=1 asserted in ISSUE at pc=3 -> instr_valid still pulses, the FSM parks in IDLE with pc=4.
- Fetch resumes at 4 one cycle after stall drops.
REQ-030 Reset mid-fetch: rst=1 during FETCH with imem_ready=1 -> next cycle pc=RESET_PC, instr=0000, instr_valid=0, and the FSM is in IDLE.
REQ-031 Wrap-around: pc=16'hFFFF issues -> next imem_addr is 16'h0000.
